// File: rtl/ad_bus_pkg.sv
// Shared types and constants for the multiplexed AD bus initiator and its helpers.
package ad_bus_pkg;

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RECOVER} ad_bus_state_t;

   localparam logic STROBE_IDLE   = 1'b1;
   localparam logic STROBE_ACTIVE = 1'b0;

   // Counter width able to hold 0..cycles; at least one bit even when disabled.
   function automatic int unsigned timer_width(input int unsigned cycles);
      return (cycles == 0) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/ad_bus_timer.sv
// Loadable saturating up-counter with terminal count at TIMEOUT_CYCLES-1.
module ad_bus_timer
   import ad_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned CNT_W          = timer_width(TIMEOUT_CYCLES)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             tc
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (load) begin
         count_d = load_val;
      end else if (en && (32'(count_q) < TIMEOUT_CYCLES)) begin
         // Saturates at TIMEOUT_CYCLES so the count can never wrap.
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc = (TIMEOUT_CYCLES != 0) && (32'(count_q) == TIMEOUT_CYCLES - 32'd1);

endmodule

// File: rtl/ad_bus_initiator.sv
// Single-outstanding AD bus master: address phase, data phase with rdy/timeout, recover.
module ad_bus_initiator
   import ad_bus_pkg::*;
#(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 16,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_timeout,
   output logic [ADDR_W-1:0] ad_out,
   output logic              ad_oe,
   input  logic [ADDR_W-1:0] ad_in,
   output logic              ale,
   output logic              read_n,
   output logic              write_n,
   input  logic              rdy
);

   localparam int unsigned TimerW = timer_width(TIMEOUT_CYCLES);

   ad_bus_state_t     state_q, state_d;
   logic              wr_q, wr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              req_ready_q, req_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_timeout_q, rsp_timeout_d;
   logic [ADDR_W-1:0] ad_out_q, ad_out_d;
   logic              ad_oe_q, ad_oe_d;
   logic              ale_q, ale_d;
   logic              read_n_q, read_n_d;
   logic              write_n_q, write_n_d;
   logic              timer_clr, timer_en, timer_tc;

   assign timer_clr = (state_q == ADDR);
   assign timer_en  = (state_q == DATA) && !rdy;

   ad_bus_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (TimerW)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .clr      (timer_clr),
      .en       (timer_en),
      .load     (1'b0),
      .load_val ({TimerW{1'b0}}),
      .tc       (timer_tc)
   );

   // Outputs are decoded for the next state so every output leaves a flop.
   always_comb begin
      state_d       = state_q;
      wr_d          = wr_q;
      wdata_d       = wdata_q;
      req_ready_d   = req_ready_q;
      rsp_valid_d   = 1'b0;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_timeout_d = rsp_timeout_q;
      ad_out_d      = ad_out_q;
      ad_oe_d       = ad_oe_q;
      ale_d         = ale_q;
      read_n_d      = read_n_q;
      write_n_d     = write_n_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid && req_ready_q) begin
               state_d     = ADDR;
               wr_d        = req_write;
               wdata_d     = req_wdata;
               req_ready_d = 1'b0;
               ad_oe_d     = 1'b1;
               ad_out_d    = req_addr;
               ale_d       = 1'b1;
            end
         end
         ADDR: begin
            state_d   = DATA;
            ale_d     = 1'b0;
            ad_oe_d   = wr_q;
            ad_out_d  = wr_q ? ADDR_W'(wdata_q) : '0;
            write_n_d = wr_q ? STROBE_ACTIVE : STROBE_IDLE;
            read_n_d  = wr_q ? STROBE_IDLE : STROBE_ACTIVE;
         end
         DATA: begin
            if (rdy || timer_tc) begin
               state_d       = RECOVER;
               ad_oe_d       = 1'b0;
               ad_out_d      = '0;
               read_n_d      = STROBE_IDLE;
               write_n_d     = STROBE_IDLE;
               rsp_valid_d   = 1'b1;
               rsp_timeout_d = !rdy;
               rsp_rdata_d   = (rdy && !wr_q) ? ad_in[DATA_W-1:0] : '0;
            end
         end
         RECOVER: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         wr_q          <= 1'b0;
         wdata_q       <= '0;
         req_ready_q   <= 1'b1;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_timeout_q <= 1'b0;
         ad_out_q      <= '0;
         ad_oe_q       <= 1'b0;
         ale_q         <= 1'b0;
         read_n_q      <= STROBE_IDLE;
         write_n_q     <= STROBE_IDLE;
      end else begin
         state_q       <= state_d;
         wr_q          <= wr_d;
         wdata_q       <= wdata_d;
         req_ready_q   <= req_ready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_timeout_q <= rsp_timeout_d;
         ad_out_q      <= ad_out_d;
         ad_oe_q       <= ad_oe_d;
         ale_q         <= ale_d;
         read_n_q      <= read_n_d;
         write_n_q     <= write_n_d;
      end
   end

   if (ADDR_W > DATA_W) begin : g_unused
      logic unused_ad_in_hi;
      assign unused_ad_in_hi = ^ad_in[ADDR_W-1:DATA_W];
   end

   assign req_ready   = req_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_timeout = rsp_timeout_q;
   assign ad_out      = ad_out_q;
   assign ad_oe       = ad_oe_q;
   assign ale         = ale_q;
   assign read_n      = read_n_q;
   assign write_n     = write_n_q;

endmodule

// File: tb/tb_ad_bus_initiator.sv
// Bench for ad_bus_initiator: per-transaction phase model checked every cycle plus literal pins.
module tb_ad_bus_initiator;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned TO     = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              req_valid, req_ready, req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid, rsp_timeout;
   logic [DATA_W-1:0] rsp_rdata;
   logic [ADDR_W-1:0] ad_out, ad_in;
   logic              ad_oe, ale, read_n, write_n, rdy;

   always #5 clk = ~clk;

   ad_bus_initiator #(
      .ADDR_W         (ADDR_W),
      .DATA_W         (DATA_W),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_timeout (rsp_timeout),
      .ad_out      (ad_out),
      .ad_oe       (ad_oe),
      .ad_in       (ad_in),
      .ale         (ale),
      .read_n      (read_n),
      .write_n     (write_n),
      .rdy         (rdy)
   );

   // Expected outputs for the current cycle, set by the stimulus alongside the inputs.
   logic              e_ready, e_rsp_valid, e_timeout, e_oe, e_ale, e_read_n, e_write_n;
   logic              e_chk_out;
   logic [DATA_W-1:0] e_rdata;
   logic [ADDR_W-1:0] e_ad_out;
   logic [DATA_W-1:0] m_rdata;
   logic              m_timeout;
   logic              chk_en = 1'b0;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int rd_low_cnt = 0;
   int prev_ale = -1;
   int gap_min = 1000;
   int gap_max = 0;
   logic [ADDR_W-1:0] cap_ale_addr, cap_wr_bus;
   logic [DATA_W-1:0] cap_rdata;
   logic              cap_to;
   int                cap_rsp_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (chk_en) begin
         chk("req_ready", 64'(req_ready), 64'(e_ready));
         chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp_valid));
         chk("rsp_rdata", 64'(rsp_rdata), 64'(e_rdata));
         chk("rsp_timeout", 64'(rsp_timeout), 64'(e_timeout));
         chk("ad_oe", 64'(ad_oe), 64'(e_oe));
         chk("ale", 64'(ale), 64'(e_ale));
         chk("read_n", 64'(read_n), 64'(e_read_n));
         chk("write_n", 64'(write_n), 64'(e_write_n));
         if (e_chk_out) chk("ad_out", 64'(ad_out), 64'(e_ad_out));
         chk("no_contention", 64'(ad_oe & ~read_n), 64'(0));
      end
      if (!read_n) rd_low_cnt++;
      if (!write_n) cap_wr_bus = ad_out;
      if (ale) begin
         cap_ale_addr = ad_out;
         if (prev_ale >= 0) begin
            if (cyc - prev_ale < gap_min) gap_min = cyc - prev_ale;
            if (cyc - prev_ale > gap_max) gap_max = cyc - prev_ale;
         end
         prev_ale = cyc;
      end
      if (rsp_valid) begin
         cap_rdata = rsp_rdata;
         cap_to    = rsp_timeout;
         cap_rsp_cnt++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      e_ready     = 1'b1;
      e_rsp_valid = 1'b0;
      e_oe        = 1'b0;
      e_ale       = 1'b0;
      e_read_n    = 1'b1;
      e_write_n   = 1'b1;
      e_chk_out   = 1'b1;
      e_ad_out    = '0;
      e_rdata     = m_rdata;
      e_timeout   = m_timeout;
   endtask

   task automatic idle_cycle();
      set_idle();
      req_valid = 1'b0;
      rdy       = 1'($urandom);
      ad_in     = $urandom;
      step();
   endtask

   // One transaction: wait_c = DATA cycles before rdy (-1 = never); adv = ad_in at the rdy cycle.
   task automatic txn(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                      input int wait_c, input logic [ADDR_W-1:0] adv, input logic hold_valid);
      logic to;
      int   n;
      to = (wait_c < 0) || (wait_c >= int'(TO));
      n  = to ? int'(TO) : wait_c + 1;
      set_idle();
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_wdata = wd;
      rdy       = 1'($urandom);
      ad_in     = $urandom;
      step();
      // ADDR
      if (hold_valid) begin
         req_write = ~wr;
         req_addr  = $urandom;
         req_wdata = DATA_W'($urandom);
      end else begin
         req_valid = 1'b0;
      end
      e_ready   = 1'b0;
      e_ale     = 1'b1;
      e_oe      = 1'b1;
      e_chk_out = 1'b1;
      e_ad_out  = a;
      rdy       = 1'($urandom);
      ad_in     = $urandom;
      step();
      // DATA
      for (int k = 0; k < n; k++) begin
         e_ale     = 1'b0;
         e_oe      = wr;
         e_chk_out = wr;
         e_ad_out  = ADDR_W'(wd);
         e_write_n = !wr;
         e_read_n  = wr;
         rdy       = !to && (k == wait_c);
         ad_in     = rdy ? adv : $urandom;
         step();
      end
      // RECOVER
      m_rdata     = (wr || to) ? '0 : adv[DATA_W-1:0];
      m_timeout   = to;
      e_oe        = 1'b0;
      e_chk_out   = 1'b0;
      e_read_n    = 1'b1;
      e_write_n   = 1'b1;
      e_rsp_valid = 1'b1;
      e_rdata     = m_rdata;
      e_timeout   = m_timeout;
      rdy         = 1'($urandom);
      ad_in       = $urandom;
      step();
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      rdy       = 1'b0;
      ad_in     = '0;
      m_rdata   = '0;
      m_timeout = 1'b0;
      set_idle();
      step();
      step();
      reset  = 1'b0;
      chk_en = 1'b1;
      idle_cycle();

      // Write, immediate rdy
      rd_low_cnt = 0;
      txn(1'b1, 32'h0000_1234, 16'hBEEF, 0, 32'h0, 1'b0);
      idle_cycle();
      chk("w_ale_addr", 64'(cap_ale_addr), 64'h0000_1234);
      chk("w_data_bus", 64'(cap_wr_bus), 64'h0000_BEEF);
      chk("w_rsp_rdata", 64'(cap_rdata), 64'h0);
      chk("w_rd_low", 64'(rd_low_cnt), 64'd0);

      // Read, rdy after 3 wait cycles
      rd_low_cnt = 0;
      txn(1'b0, 32'h8000_0010, 16'h0, 3, 32'hFFFF_5A5A, 1'b0);
      chk("r_ale_addr", 64'(cap_ale_addr), 64'h8000_0010);
      chk("r_rd_low", 64'(rd_low_cnt), 64'd4);
      chk("r_rsp_rdata", 64'(cap_rdata), 64'h5A5A);
      chk("r_rsp_to", 64'(cap_to), 64'd0);

      // Read, rdy never asserted
      rd_low_cnt = 0;
      txn(1'b0, 32'h0000_0ABC, 16'h0, -1, 32'h0, 1'b0);
      chk("to_rd_low", 64'(rd_low_cnt), 64'd16);
      chk("to_rsp_to", 64'(cap_to), 64'd1);
      chk("to_rsp_rdata", 64'(cap_rdata), 64'h0);

      // rdy on the last allowed DATA cycle wins over the timeout
      rd_low_cnt = 0;
      txn(1'b0, 32'h0000_0044, 16'h0, 15, 32'h1234_C3C3, 1'b0);
      chk("edge_rd_low", 64'(rd_low_cnt), 64'd16);
      chk("edge_rsp_to", 64'(cap_to), 64'd0);
      chk("edge_rsp_rdata", 64'(cap_rdata), 64'hC3C3);

      txn(1'b1, 32'hDEAD_0008, 16'h7E81, 2, 32'h0, 1'b0);
      idle_cycle();

      // Reset during the second DATA cycle of a read
      cap_rsp_cnt = 0;
      set_idle();
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 32'h0000_0F00;
      step();
      req_valid = 1'b0;
      e_ready   = 1'b0;
      e_ale     = 1'b1;
      e_oe      = 1'b1;
      e_ad_out  = 32'h0000_0F00;
      rdy       = 1'b0;
      step();
      e_ale     = 1'b0;
      e_oe      = 1'b0;
      e_chk_out = 1'b0;
      e_read_n  = 1'b0;
      step();
      reset = 1'b1;
      step();
      reset     = 1'b0;
      m_rdata   = '0;
      m_timeout = 1'b0;
      rdy       = 1'b1;
      ad_in     = 32'hFFFF_FFFF;
      set_idle();
      step();
      idle_cycle();
      chk("rst_no_rsp", 64'(cap_rsp_cnt), 64'd0);

      // Four back-to-back reads with req_valid held high
      prev_ale = -1;
      gap_min  = 1000;
      gap_max  = 0;
      for (int i = 0; i < 4; i++) begin
         txn(1'b0, 32'h0000_0100 + 32'(i), 16'h0, 0, 32'h0000_1110 * 32'(i + 1), 1'b1);
      end
      idle_cycle();
      idle_cycle();
      chk("b2b_gap_min", 64'(gap_min), 64'd4);
      chk("b2b_gap_max", 64'(gap_max), 64'd4);
      chk("b2b_last_rdata", 64'(cap_rdata), 64'h4440);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ad_bus_initiator.md
Name: ad_bus_initiator

Overview:
- Initiator (bus master) for the multiplexed address/data bus whose responders drive read data back onto AD under control of the active-low read strobe.
- Accepts single read/write requests on a valid/ready interface and runs an address phase, then a data phase.
- Waits for responder ready, bounded by a timeout, and returns one response per request.
- Sits between the register-access fabric and the shared AD pad/tristate logic, which is instantiated outside this block.

Parameters:
- ADDR_W, 32, width of the AD bus and of the request address.
- DATA_W, 16, width of read/write data; must satisfy DATA_W <= ADDR_W.
- TIMEOUT_CYCLES, 16, maximum number of data-phase cycles before abort; 0 disables the timeout.

Ports:
- clk  input  1  sole clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  initiator can accept a request.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  transaction address.
- req_wdata  input  DATA_W  write data.
- rsp_valid  output  1  one-cycle pulse; response fields are valid.
- rsp_rdata  output  DATA_W  read data; 0 for writes and for timeouts.
- rsp_timeout  output  1  qualifies rsp_valid; transaction aborted.
- ad_out  output  ADDR_W  value driven onto AD when ad_oe=1.
- ad_oe  output  1  AD output enable.
- ad_in  input  ADDR_W  sampled AD bus.
- ale  output  1  address latch enable, high during the address phase.
- read_n  output  1  active-low read strobe.
- write_n  output  1  active-low write strobe.
- rdy  input  1  responder ready/data-valid.

Behaviour:
- Reset values (and IDLE values): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_timeout=0, ad_out=0, ad_oe=0, ale=0, read_n=1, write_n=1, timer=0.
- All outputs are Moore outputs decoded from state flops plus registered capture fields. There are no combinational input-to-output paths.
- IDLE: req_ready=1. A handshake is req_valid && req_ready. On a handshake, capture write, addr and wdata, then go to ADDR.
- ADDR (exactly 1 cycle): ad_oe=1, ad_out=addr, ale=1, strobes high, req_ready=0. Go to DATA.
- DATA, write: ad_oe=1, ad_out = {zeros, wdata} (upper ADDR_W-DATA_W bits 0), write_n=0.
- DATA, read: ad_oe=0 (bus released to the responder), read_n=0.
- DATA, all cycles: ale=0. rdy is sampled every cycle starting with the first DATA cycle.
- DATA exit on rdy=1: go to RECOVER. For a read, capture ad_in[DATA_W-1:0] into rsp_rdata.
- DATA exit on timeout: rdy=0 and timer == TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES>0). Go to RECOVER with timeout flag set and rdata=0. rdy wins over the timeout in the same cycle.
- Timer: clears on entry to DATA and increments each DATA cycle while rdy=0. Width is $clog2(TIMEOUT_CYCLES+1). It must never wrap.
- RECOVER (exactly 1 cycle): all strobes deasserted, ad_oe=0, rsp_valid=1 together with rsp_rdata and rsp_timeout, req_ready=0. Go to IDLE.
- rsp_rdata and rsp_timeout hold their values until the next RECOVER.
- Latency: handshake at cycle 0 → ADDR at 1 → DATA at 2 → rsp_valid at 3 (if rdy at 2) → req_ready at 4. Minimum 4 cycles per transaction; there is no pipelining and no response backpressure.
- req_* inputs are ignored outside IDLE. rdy and ad_in are ignored outside DATA.
- Reset mid-transaction: IDLE on the next edge with the reset values above. No rsp_valid is produced for the aborted transaction.
- ad_oe and read_n=0 are never both asserted in the same cycle, so there is no bus contention by construction.

Decomposition:
- Package ad_bus_pkg holds:
  - typedef enum logic [1:0] {IDLE, ADDR, DATA, RECOVER} ad_bus_state_t;
  - localparams for the strobe idle levels (STROBE_IDLE = 1'b1).
- One sub-module, ad_bus_timer. It is a loadable up-counter with clear and enable inputs and a terminal-count output at TIMEOUT_CYCLES-1, and it is shared with future responder-side watchdogs.

Test Plan:
- Write, responder asserts rdy on the first DATA cycle; addr=32'h0000_1234, wdata=16'hBEEF:
  - cycle 1: ale=1, ad_oe=1, ad_out=32'h0000_1234;
  - cycle 2: write_n=0, ad_out=32'h0000_BEEF;
  - cycle 3: rsp_valid=1, rsp_timeout=0, rsp_rdata=0;
  - cycle 4: req_ready=1.
- Read, addr=32'h8000_0010, rdy after 3 wait cycles, ad_in=32'hFFFF_5A5A at the rdy cycle → read_n=0 and ad_oe=0 for 4 DATA cycles; rsp_rdata=16'h5A5A, rsp_timeout=0.
- Read with rdy never asserted, TIMEOUT_CYCLES=16 → exactly 16 DATA cycles, then rsp_valid=1, rsp_timeout=1, rsp_rdata=0; next request accepted normally.
- rdy=1 on the 16th DATA cycle (timer=15) → completion with rsp_timeout=0, not a timeout.
- reset=1 for one cycle during DATA → next cycle all outputs at reset values, req_ready=1, no rsp_valid pulse.
- req_valid held high with 4 back-to-back reads (rdy immediate) → handshakes exactly every 4 cycles; ad_oe and read_n=0 never overlap in any cycle.
